// File: rtl/carry_bypass_accum16.sv
// Burst accumulator: sums 16-bit beats modulo 2^16 and counts carry-outs and beats,
// presenting the burst result with a valid/ready handshake until it is consumed.
module carry_bypass_accum16 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic [CNT_W-1:0] out_carry_cnt,
  output logic [CNT_W-1:0] out_beat_cnt,
  output logic             out_sat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             consume;
  logic [16:0]      sum_full;

  always_comb begin
    in_ready = !rst && (state_q != S_HOLD);
    accept   = in_valid && in_ready;
    consume  = out_valid_q && out_ready;
    sum_full = {1'b0, acc_q} + {1'b0, in_data};
  end

  // Counters stop at CNT_MAX; the overflow that would have happened is recorded in sat.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carry_cnt_d = carry_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      acc_d = sum_full[15:0];
      if (sum_full[16]) begin
        if (carry_cnt_q == CNT_MAX) sat_d = 1'b1;
        else                        carry_cnt_d = carry_cnt_q + CNT_W'(1);
      end
      if (beat_cnt_q == CNT_MAX) sat_d = 1'b1;
      else                       beat_cnt_d = beat_cnt_q + CNT_W'(1);
      state_d     = in_last ? S_HOLD : S_ACC;
      out_valid_d = in_last;
    end else if (consume) begin
      acc_d       = '0;
      carry_cnt_d = '0;
      beat_cnt_d  = '0;
      sat_d       = 1'b0;
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      carry_cnt_q <= '0;
      beat_cnt_q  <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_cnt_q <= carry_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    out_valid     = out_valid_q;
    out_sum       = out_valid_q ? acc_q       : '0;
    out_carry_cnt = out_valid_q ? carry_cnt_q : '0;
    out_beat_cnt  = out_valid_q ? beat_cnt_q  : '0;
    out_sat       = out_valid_q ? sat_q       : 1'b0;
  end

endmodule

// File: tb/tb_carry_bypass_accum16.sv
// Directed bench for carry_bypass_accum16: hand-computed burst results, stall/hold,
// saturation, mid-burst reset and a randomly throttled burst against a running total.
module tb_carry_bypass_accum16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_carry_cnt;
  logic [7:0]  out_beat_cnt;
  logic        out_sat;

  int unsigned passes = 0;
  int unsigned total  = 0;

  carry_bypass_accum16 #(.CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_carry_cnt (out_carry_cnt),
    .out_beat_cnt  (out_beat_cnt),
    .out_sat       (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat until it is accepted (bounded), then drop in_valid.
  task automatic send_beat(input logic [15:0] d, input logic l);
    int unsigned n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    check("beat_accepted", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'h0000;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("consume_valid_clr", {31'd0, out_valid}, 32'd0);
    check("consume_ready_set", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [15:0] s, input logic [7:0] c,
                              input logic [7:0] b, input logic sat);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_sum"},   {16'd0, out_sum}, {16'd0, s});
    check({tag, "_carry"}, {24'd0, out_carry_cnt}, {24'd0, c});
    check({tag, "_beats"}, {24'd0, out_beat_cnt}, {24'd0, b});
    check({tag, "_sat"},   {31'd0, out_sat}, {31'd0, sat});
  endtask

  initial begin
    logic [15:0] rvals [10];
    logic [31:0] exp_total;
    logic [31:0] obs_total;
    int unsigned idx;
    int unsigned guard;
    logic        got;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_last = 1'b1; in_data = 16'hBEEF;
    step(); step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // out_ready while idle is ignored
    out_ready = 1'b1;
    step(); step();
    check("idle_ready_noop", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // 1 + 2 + 3
    send_beat(16'h0001, 1'b0);
    send_beat(16'h0002, 1'b0);
    check("mid_burst_no_valid", {31'd0, out_valid}, 32'd0);
    send_beat(16'h0003, 1'b1);
    check_result("b037", 16'h0006, 8'd0, 8'd3, 1'b0);
    consume();

    // carries
    send_beat(16'hFFFF, 1'b0);
    send_beat(16'h0001, 1'b0);
    send_beat(16'h8000, 1'b0);
    send_beat(16'h8000, 1'b1);
    check_result("b038", 16'h0000, 8'd2, 8'd4, 1'b0);
    consume();

    // single-beat burst, consumer stalls, new beats ignored while holding
    send_beat(16'h1234, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 16'hAAAA;
      in_last  = 1'b1;
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      check_result("b039_hold", 16'h1234, 8'd0, 8'd1, 1'b0);
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    consume();
    send_beat(16'h0007, 1'b1);
    check_result("b039_next", 16'h0007, 8'd0, 8'd1, 1'b0);
    consume();

    // saturation: 300 x 0xFFFF, 299 carries, acc = 0x10000 - 300
    for (int i = 0; i < 300; i++) send_beat(16'hFFFF, (i == 299) ? 1'b1 : 1'b0);
    check_result("b040_sat", 16'hFED4, 8'd255, 8'd255, 1'b1);
    consume();
    send_beat(16'h0005, 1'b1);
    check_result("b040_after", 16'h0005, 8'd0, 8'd1, 1'b0);
    consume();

    // reset mid-burst discards partial sum
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0100, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1; in_data = 16'h0100; in_last = 1'b1;
    #1;
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("rst_mid_no_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    #1;
    check("rst_mid_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    check("rst_mid_still_idle", {31'd0, out_valid}, 32'd0);
    send_beat(16'h0010, 1'b1);
    check_result("b041", 16'h0010, 8'd0, 8'd1, 1'b0);

    // reset during hold drops the pending result
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_hold_drop", {31'd0, out_valid}, 32'd0);

    // randomly throttled 10-beat burst
    rvals = '{16'hF00D, 16'h9000, 16'h0001, 16'hC3A5, 16'h8001,
              16'h7FFF, 16'hFFFE, 16'h1234, 16'hA5A5, 16'h4000};
    exp_total = 32'd0;
    foreach (rvals[k]) exp_total += {16'd0, rvals[k]};
    idx = 0;
    guard = 0;
    while (idx < 10 && guard < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = rvals[idx];
      in_last  = (idx == 9);
      @(negedge clk);
      got = in_valid && in_ready;
      step();
      if (got) idx++;
      guard++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    check("rand_all_beats_sent", idx, 32'd10);
    obs_total = {8'd0, out_carry_cnt, 16'd0} + {16'd0, out_sum};
    check("rand_total", obs_total, exp_total);
    check("rand_beats", {24'd0, out_beat_cnt}, 32'd10);
    check("rand_valid", {31'd0, out_valid}, 32'd1);
    check("rand_sat", {31'd0, out_sat}, 32'd0);
    consume();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
